// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the operand selector: mode encodings and mode decode helpers.
//   MODE_DIRECT  2'b00  index comes from sel
//   MODE_RR      2'b01  index comes from the internal round-robin pointer
//   MODE_HOLD    2'b10  no new transfers accepted
//   2'b11        reserved, behaves as MODE_DIRECT
package mux_pipe_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_DIRECT = 2'b00;
  localparam logic [MODE_W-1:0] MODE_RR     = 2'b01;
  localparam logic [MODE_W-1:0] MODE_HOLD   = 2'b10;

  // True when the effective index comes from the round-robin pointer.
  function automatic logic mode_is_rr(input logic [MODE_W-1:0] mode);
    return mode == MODE_RR;
  endfunction

  // True when the block may accept a new transfer in this mode.
  function automatic logic mode_accepts(input logic [MODE_W-1:0] mode);
    return mode != MODE_HOLD;
  endfunction

endpackage

// File: rtl/mux_n.sv
// Purely combinational WIDTH x N_IN selector. Out-of-range selects return zero
// and raise oor_c.
// Ports:
//   in_data  N_IN*WIDTH  flattened inputs, input i at [i*WIDTH +: WIDTH]
//   sel      SEL_W       source index
//   y_c      WIDTH       selected input, or zero when sel >= N_IN
//   oor_c    1           sel >= N_IN
module mux_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      y_c,
  output logic                  oor_c
);

  // Compare-and-pick avoids a variable-width multiply in the part-select index.
  always_comb begin
    y_c = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) y_c = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign oor_c = (32'(sel) >= N_IN);

endmodule

// File: rtl/mux_pipe.sv
// Registered N-input operand selector with valid/ready handshake. Selects by sel
// (direct) or by an internal round-robin pointer, and holds the result in one
// output register that accepts and drains in the same cycle.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_data      N_IN*WIDTH flattened inputs
//   in_valid     upstream offers a transfer
//   in_ready     combinational: block can accept this cycle
//   sel          direct-mode source index
//   mode         00 direct, 01 round-robin, 10 hold, 11 direct
//   out_data     registered selected value
//   out_src      index captured with out_data
//   out_valid    out_data holds an unconsumed value
//   out_ready    downstream consumes out_data this cycle
//   sel_err      last accepted index was out of range
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      N_IN    = 4,
  parameter int unsigned      SEL_W   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [MODE_W-1:0]     mode,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  // Selector must be wide enough to address every input.
  if (SEL_W < $clog2(N_IN)) begin : g_sel_w_check
    $error("mux_pipe: SEL_W=%0d too narrow for N_IN=%0d", SEL_W, N_IN);
  end

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] idx_c;
  logic [WIDTH-1:0] mux_y_c;
  logic             mux_oor_c;
  logic             accept_c;
  logic             consume_c;

  assign idx_c     = mode_is_rr(mode) ? rr_ptr : sel;
  assign in_ready  = mode_accepts(mode) & (~out_valid | out_ready);
  assign accept_c  = in_valid & in_ready;
  assign consume_c = out_valid & out_ready;

  mux_n #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data (in_data),
    .sel     (idx_c),
    .y_c     (mux_y_c),
    .oor_c   (mux_oor_c)
  );

  // Output register: an accept wins over a consume, so both in one cycle streams.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= RST_VAL;
      out_src   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (accept_c) begin
      out_data  <= mux_y_c;
      out_src   <= idx_c;
      out_valid <= 1'b1;
      sel_err   <= mux_oor_c;
    end else if (consume_c) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves only when it was actually used for an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept_c && mode_is_rr(mode)) begin
      if (rr_ptr == SEL_W'(N_IN - 1)) rr_ptr <= '0;
      else                            rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
module tb_mux_pipe;

  logic clk;
  logic rst_n;

  // Instance A: N_IN=4, WIDTH=8, RST_VAL=0
  logic [31:0] a_in_data;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_err;
  logic [1:0]  a_sel, a_mode, a_out_src;
  logic [7:0]  a_out_data;

  // Instance B: N_IN=3, WIDTH=8, RST_VAL=0x5A
  logic [23:0] b_in_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err;
  logic [1:0]  b_sel, b_mode, b_out_src;
  logic [7:0]  b_out_data;

  int n_cmp;
  int n_bad;

  mux_pipe #(.WIDTH(8), .N_IN(4), .SEL_W(2), .RST_VAL(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
    .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sel_err(a_sel_err)
  );

  mux_pipe #(.WIDTH(8), .N_IN(3), .SEL_W(2), .RST_VAL(8'h5A)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
    .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sel_err(b_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int    n_acc;
    logic  vpat [9];
    n_cmp = 0;
    n_bad = 0;
    vpat  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_n       = 1'b0;
    a_in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    a_in_valid  = 1'b0;
    a_sel       = 2'd0;
    a_mode      = 2'b00;
    a_out_ready = 1'b0;
    b_in_data   = {8'hA2, 8'hA1, 8'hA0};
    b_in_valid  = 1'b0;
    b_sel       = 2'd0;
    b_mode      = 2'b00;
    b_out_ready = 1'b0;

    // Reset state
    #12;
    check("a_rst_valid", 32'(a_out_valid), 32'd0);
    check("a_rst_data",  32'(a_out_data),  32'h00);
    check("a_rst_src",   32'(a_out_src),   32'd0);
    check("a_rst_err",   32'(a_sel_err),   32'd0);
    check("a_rst_ready", 32'(a_in_ready),  32'd1);
    check("b_rst_data",  32'(b_out_data),  32'h5A);
    rst_n = 1'b1;

    // Direct select, streaming one per cycle
    a_sel = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
    step();
    check("dir_data0", 32'(a_out_data),  32'h33);
    check("dir_src0",  32'(a_out_src),   32'd2);
    check("dir_vld0",  32'(a_out_valid), 32'd1);
    a_sel = 2'd0; step();
    check("dir_data1", 32'(a_out_data), 32'h11);
    a_sel = 2'd3; step();
    check("dir_data2", 32'(a_out_data), 32'h44);
    check("dir_src2",  32'(a_out_src),  32'd3);
    a_sel = 2'd1; step();
    check("dir_data3", 32'(a_out_data), 32'h22);

    // Back-pressure: output frozen while downstream stalls
    a_out_ready = 1'b0; a_sel = 2'd0;
    #1;
    check("bp_ready0", 32'(a_in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", 32'(a_out_data), 32'h22);
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_ready1", 32'(a_in_ready), 32'd1);
    step();
    check("bp_next_data", 32'(a_out_data),  32'h11);
    check("bp_next_vld",  32'(a_out_valid), 32'd1);
    a_in_valid = 1'b0; step();
    check("drain_vld",  32'(a_out_valid), 32'd0);
    check("drain_data", 32'(a_out_data),  32'h11);

    // Round-robin on N_IN=3 with stall cycles; sel must be ignored
    b_mode = 2'b01; b_sel = 2'd3; b_out_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      b_in_valid = vpat[i];
      step();
      if (vpat[i]) begin
        check("rr_src",  32'(b_out_src),  32'(n_acc % 3));
        check("rr_data", 32'(b_out_data), 32'(8'hA0 + 8'(n_acc % 3)));
        n_acc++;
      end else begin
        check("rr_stall_vld", 32'(b_out_valid), 32'd0);
      end
    end
    check("rr_count", 32'(n_acc), 32'd7);

    // Out-of-range direct select, then recovery
    b_mode = 2'b00; b_sel = 2'd3; b_in_valid = 1'b1;
    step();
    check("oor_data", 32'(b_out_data), 32'h00);
    check("oor_err",  32'(b_sel_err),  32'd1);
    check("oor_src",  32'(b_out_src),  32'd3);
    b_sel = 2'd1; step();
    check("oor_clr_data", 32'(b_out_data), 32'hA1);
    check("oor_clr_err",  32'(b_sel_err),  32'd0);

    // Hold mode: no accepts, pending output drains once
    b_out_ready = 1'b0; b_mode = 2'b10; b_sel = 2'd2;
    #1;
    check("hold_ready", 32'(b_in_ready), 32'd0);
    step(); step();
    check("hold_data", 32'(b_out_data),  32'hA1);
    check("hold_vld",  32'(b_out_valid), 32'd1);
    check("hold_src",  32'(b_out_src),   32'd1);
    b_out_ready = 1'b1;
    #1;
    check("hold_ready2", 32'(b_in_ready), 32'd0);
    step();
    check("hold_drain_vld",  32'(b_out_valid), 32'd0);
    check("hold_drain_data", 32'(b_out_data),  32'hA1);
    step();
    check("hold_idle_vld", 32'(b_out_valid), 32'd0);

    // Asynchronous reset mid-stream: pointer is at 1 after the 7 rr accepts
    b_mode = 2'b01; b_in_valid = 1'b1;
    step();
    check("pre_rst_src", 32'(b_out_src), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_vld",  32'(b_out_valid), 32'd0);
    check("arst_data", 32'(b_out_data),  32'h5A);
    check("arst_src",  32'(b_out_src),   32'd0);
    step();
    check("rst_no_xfer", 32'(b_out_valid), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_src",  32'(b_out_src),   32'd0);
    check("post_rst_data", 32'(b_out_data),  32'hA0);
    check("post_rst_vld",  32'(b_out_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
